// File: rtl/store_monitor_if.sv
// Store monitor bus: processor store strobe in, store-log FIFO and verdict out.
// The master drives stores and pops; the slave is the monitor.
interface store_monitor_if #(
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          memwrite;
    logic [31:0]   dataadr;
    logic [31:0]   writedata;
    logic          log_rd;
    logic          log_valid;
    logic [31:0]   log_addr;
    logic [31:0]   log_data;
    logic [CW-1:0] log_count;
    logic          overflow;
    logic          done;
    logic          pass;
    logic [1:0]    fail_code;

    modport master (
        output memwrite, dataadr, writedata, log_rd,
        input  log_valid, log_addr, log_data, log_count,
        input  overflow, done, pass, fail_code
    );

    modport slave (
        input  memwrite, dataadr, writedata, log_rd,
        output log_valid, log_addr, log_data, log_count,
        output overflow, done, pass, fail_code
    );
endinterface

// File: rtl/store_monitor.sv
// Watches processor stores for a pass/fail signature and a run timeout,
// logging every store seen while running into a first-word-fall-through FIFO.
module store_monitor #(
    parameter logic [31:0] PASS_ADDR  = 32'd84,
    parameter logic [31:0] PASS_DATA  = 32'hFFFF7F02,
    parameter logic [31:0] ALLOW_ADDR = 32'd80,
    parameter int          DEPTH      = 8,
    parameter int          TIMEOUT    = 1000
) (
    input  logic           clk,
    input  logic           reset,
    store_monitor_if.slave bus
);
    localparam int          AW      = $clog2(DEPTH);
    localparam int          CW      = AW + 1;
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);
    localparam logic [CW-1:0] FULL  = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_RUN,
        S_PASS,
        S_FAIL
    } state_e;

    state_e        state_q;
    logic [31:0]   cnt_q;
    logic          done_q;
    logic          pass_q;
    logic [1:0]    code_q;

    logic [31:0]   addr_mem [DEPTH];
    logic [31:0]   data_mem [DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          ovf_q;

    logic running;
    logic is_pass;
    logic push_req;
    logic pop;
    logic full;
    logic push;

    assign running  = (state_q == S_RUN);
    assign is_pass  = (bus.dataadr == PASS_ADDR) &&
                      (bus.writedata == PASS_DATA);
    assign push_req = running && bus.memwrite;
    assign pop      = bus.log_rd && (count_q != '0);
    assign full     = (count_q == FULL);
    // A pop on the same edge frees the slot the incoming store needs.
    assign push     = push_req && (!full || pop);

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // A deciding store outranks the timeout in the same cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_RUN;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            code_q  <= 2'b00;
        end else if (running) begin
            cnt_q <= cnt_q + 32'd1;
            if (bus.memwrite && is_pass) begin
                state_q <= S_PASS;
                done_q  <= 1'b1;
                pass_q  <= 1'b1;
                code_q  <= 2'b00;
            end else if (bus.memwrite && bus.dataadr != ALLOW_ADDR) begin
                state_q <= S_FAIL;
                done_q  <= 1'b1;
                code_q  <= 2'b01;
            end else if (cnt_q == TO_LAST) begin
                state_q <= S_FAIL;
                done_q  <= 1'b1;
                code_q  <= 2'b10;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (push) wr_q <= wr_q + 1'b1;
            if (pop)  rd_q <= rd_q + 1'b1;
            count_q <= count_d;
            if (push_req && full && !pop) ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_q] <= bus.dataadr;
            data_mem[wr_q] <= bus.writedata;
        end
    end

    assign bus.log_valid = (count_q != '0);
    assign bus.log_addr  = addr_mem[rd_q];
    assign bus.log_data  = data_mem[rd_q];
    assign bus.log_count = count_q;
    assign bus.overflow  = ovf_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.fail_code = code_q;
endmodule

// File: doc/store_monitor.md
STORE_MONITOR -- requirements
Module: store_monitor

Interface
REQ-001 Parameter PASS_ADDR, default 32'd84, is the data address whose store ends the run.
REQ-002 Parameter PASS_DATA, default 32'hFFFF7F02 (-33022), is the value required at PASS_ADDR for a pass.
REQ-003 Parameter ALLOW_ADDR, default 32'd80, is the only other address a store may target without failing.
REQ-004 Parameter DEPTH, default 8 (power of 2, >=2), is the number of store-log entries.
REQ-005 Parameter TIMEOUT, default 1000, is the maximum number of RUN cycles allowed before a verdict.
REQ-006 clk  in  1  single clock; all state updates on the rising edge.
REQ-007 reset  in  1  synchronous, active-low reset.
REQ-008 memwrite  in  1  processor store strobe, one store per asserted cycle.
REQ-009 dataadr  in  32  store byte address.
REQ-010 writedata  in  32  store data.
REQ-011 log_rd  in  1  pop the head log entry; ignored when log_valid=0.
REQ-012 log_valid  out  1  log holds at least one entry.
REQ-013 log_addr  out  32  head entry address (first-word-fall-through).
REQ-014 log_data  out  32  head entry data.
REQ-015 log_count  out  $clog2(DEPTH)+1  entries held, 0..DEPTH.
REQ-016 overflow  out  1  sticky: a store was dropped because the log was full.
REQ-017 done  out  1  verdict reached (state PASS or FAIL).
REQ-018 pass  out  1  state is PASS.
REQ-019 fail_code  out  2  00 none/pass, 01 illegal store, 10 timeout.

Function
REQ-020 The FSM SHALL have states RUN, PASS, FAIL; PASS and FAIL are terminal until reset.
REQ-021 In RUN with memwrite=1, dataadr==PASS_ADDR and writedata==PASS_DATA, the next state SHALL be PASS.
REQ-022 In RUN with memwrite=1, any store not matching REQ-021 whose dataadr!=ALLOW_ADDR SHALL move to FAIL with fail_code=01, including a PASS_ADDR store with wrong data.
REQ-023 In RUN with memwrite=1 and dataadr==ALLOW_ADDR, the state SHALL remain RUN.
REQ-024 A RUN cycle counter SHALL increment each RUN cycle; when it equals TIMEOUT-1 and no store decides the verdict that cycle, next state SHALL be FAIL with fail_code=10.
REQ-025 A store deciding the verdict in the same cycle as timeout SHALL take priority over the timeout.
REQ-026 done, pass, fail_code SHALL be registered and change one cycle after the deciding edge's inputs are sampled.
REQ-027 Every memwrite cycle in RUN, including the deciding store, SHALL push {dataadr, writedata} into the log; stores in PASS/FAIL SHALL be ignored.
REQ-028 The log SHALL be a FIFO; log_addr/log_data SHALL show the oldest entry whenever log_valid=1 and are don't-care otherwise.
REQ-029 log_rd with log_valid=1 SHALL remove the head on the clock edge; log_count SHALL decrement by one.
REQ-030 Push when full without a simultaneous pop SHALL drop the store and set overflow; the verdict logic SHALL still evaluate the dropped store.
REQ-031 Simultaneous push and pop when full SHALL succeed with log_count unchanged and overflow unaffected.
REQ-032 Simultaneous push and pop when empty SHALL leave one entry (the new store) and log_count=1.
REQ-033 Pointers SHALL wrap modulo DEPTH without losing or duplicating entries.
REQ-034 log_rd SHALL continue to drain the log in PASS and FAIL.

Reset
REQ-035 reset=0 at a rising edge SHALL force state RUN, counter 0, log empty, log_count=0, log_valid=0, overflow=0, done=0, pass=0, fail_code=00.
REQ-036 Reset SHALL override all other inputs in that cycle, including an in-progress verdict, timeout or push/pop.
REQ-037 Reset asserted mid-run SHALL discard all logged entries.

Verification
REQ-038 Release reset; stores (80,7),(84,32'hFFFF7F02) -> done=1, pass=1, fail_code=00 one cycle later, log_count=2, head (80,7).
REQ-039 Store (84,32'h000000FE) -> done=1, pass=0, fail_code=01; later store (84,32'hFFFF7F02) -> verdict unchanged, log_count stays 1.
REQ-040 TIMEOUT=16, no stores -> fail_code=10, done=1 after 16 RUN cycles; with store (84,PASS_DATA) on cycle 16 -> pass=1 instead.
REQ-041 DEPTH=8: nine stores to 80 without log_rd -> log_count=8, overflow=1, state RUN; then one pop plus push same cycle when full -> log_count=8, order preserved.
REQ-042 Fill 5, pop 5, push 6 with interleaved pops -> popped sequence equals pushed sequence across pointer wrap.
REQ-043 Reset asserted the cycle after PASS with 3 entries logged -> all outputs at REQ-035 values next cycle.
